// File: rtl/updown_counter_191_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_pkg
// Shared constants and helpers for the cascadable up/down counter.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package counter_pkg;

  localparam int   NIBBLE_W = 4;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Nibble value a stage must hold before it passes a carry/borrow upward
  function automatic logic [NIBBLE_W-1:0] terminal_nibble(input logic dir);
    return (dir == DIR_DOWN) ? 4'h0 : 4'hF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/updown_counter_191_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// updown_counter_191_if
// Control, data and status bundle of the up/down counter.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface updown_counter_191_if #(
  parameter int STAGES = 2
);
  localparam int W = 4 * STAGES;

  logic         LOAD_n;
  logic         CTEN_n;
  logic         D_U;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         MAX_MIN;
  logic         RCO_n;
  logic         WRAP;

  // Driver side: supplies controls and load data, observes count/status
  modport master (
    output LOAD_n, CTEN_n, D_U, D,
    input  Q, MAX_MIN, RCO_n, WRAP
  );

  // Counter side
  modport slave (
    input  LOAD_n, CTEN_n, D_U, D,
    output Q, MAX_MIN, RCO_n, WRAP
  );
endinterface
`default_nettype wire

// File: rtl/updown_counter_191_nibble.sv
`default_nettype none
// ----------------------------------------------------------------------------
// updown_nibble
// One 4-bit stage: sync clear, parallel load, step up/down on cascade enable.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module updown_nibble
  import counter_pkg::*;
(
  input  wire logic                clk,
  input  wire logic                clr,
  input  wire logic                load_n,
  input  wire logic [NIBBLE_W-1:0] ld_data,
  input  wire logic                dir,
  input  wire logic                step_in,
  output logic [NIBBLE_W-1:0]      q,
  output logic                     term,
  output logic                     step_out
);

  logic [NIBBLE_W-1:0] q_q;
  logic [NIBBLE_W-1:0] q_d;

  // Next nibble value: load beats counting, otherwise step when enabled
  always_comb begin
    q_d = q_q;
    if (!load_n) begin
      q_d = ld_data;
    end else if (step_in) begin
      q_d = (dir == DIR_DOWN) ? (q_q - 4'd1) : (q_q + 4'd1);
    end
  end

  // Stage register with synchronous clear taking precedence
  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Terminal is ungated; the cascade output only passes an enabled step
  always_comb begin
    q        = q_q;
    term     = (q_q == terminal_nibble(dir));
    step_out = step_in & term;
  end

endmodule
`default_nettype wire

// File: rtl/updown_counter_191.sv
`default_nettype none
// ----------------------------------------------------------------------------
// updown_counter_191
// Presettable, cascadable up/down counter built from 4-bit stages, with
// terminal-count flag, active-low ripple carry/borrow and registered wrap.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module updown_counter_191
  import counter_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  wire logic           CLK,
  input  wire logic           CLR,
  updown_counter_191_if.slave bus
);

  logic [STAGES-1:0] step;
  logic [STAGES-1:0] cas;
  logic [STAGES-1:0] term;
  logic              wrap_q;
  logic              wrap_d;

  // Stage 0 steps on the enable alone; each higher stage waits on the chain
  assign step[0] = ~bus.CTEN_n;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k > 0) begin : g_chain
      assign step[k] = cas[k-1];
    end

    updown_nibble u_nibble (
      .clk      (CLK),
      .clr      (CLR),
      .load_n   (bus.LOAD_n),
      .ld_data  (bus.D[k*NIBBLE_W +: NIBBLE_W]),
      .dir      (bus.D_U),
      .step_in  (step[k]),
      .q        (bus.Q[k*NIBBLE_W +: NIBBLE_W]),
      .term     (term[k]),
      .step_out (cas[k])
    );
  end

  // Whole-word terminal is the AND of stage terminals; the top cascade
  // output already equals MAX_MIN & ~CTEN_n, so RCO_n is its inverse
  always_comb begin
    bus.MAX_MIN = &term;
    bus.RCO_n   = ~cas[STAGES-1];
  end

  // Wrap occurs only on an enabled count from terminal; clear/load suppress it
  always_comb begin
    wrap_d = 1'b0;
    if (bus.LOAD_n && !bus.CTEN_n) begin
      wrap_d = bus.MAX_MIN;
    end
  end

  // Registered one-cycle wrap pulse
  always_ff @(posedge CLK) begin
    if (CLR) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign bus.WRAP = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_191.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_updown_counter_191
// Directed scenarios plus randomized traffic against a behavioural model.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_updown_counter_191;

  localparam int STAGES = 2;
  localparam int W      = 4 * STAGES;
  localparam int MOD    = 1 << W;

  logic CLK = 1'b0;
  logic CLR = 1'b0;

  updown_counter_191_if #(.STAGES(STAGES)) bus ();

  updown_counter_191 #(.STAGES(STAGES)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int unsigned m_q     = 0;
  bit          m_wrap  = 1'b0;
  bit          m_valid = 1'b0;
  int          wrap_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_term(input int unsigned q, input bit du);
    return du ? (q == 0) : (q == MOD - 1);
  endfunction

  // Apply one cycle of inputs: check combinational flags, clock, check state
  task automatic step(input bit clr, input bit load_n, input bit cten_n,
                      input bit du, input logic [W-1:0] d);
    bit t;
    CLR        = clr;
    bus.LOAD_n = load_n;
    bus.CTEN_n = cten_n;
    bus.D_U    = du;
    bus.D      = d;
    #1;
    if (m_valid) begin
      t = m_term(m_q, du);
      chk("max_min", {31'd0, bus.MAX_MIN}, {31'd0, t});
      chk("rco_n",   {31'd0, bus.RCO_n},   {31'd0, ~(t & ~cten_n)});
    end
    @(posedge CLK);
    if (clr) begin
      m_q = 0; m_wrap = 1'b0;
    end else if (!load_n) begin
      m_q = d; m_wrap = 1'b0;
    end else if (!cten_n) begin
      m_wrap = m_term(m_q, du);
      m_q    = du ? (m_q + MOD - 1) % MOD : (m_q + 1) % MOD;
    end else begin
      m_wrap = 1'b0;
    end
    m_valid = 1'b1;
    #1;
    chk("q",    {24'd0, bus.Q},      m_q);
    chk("wrap", {31'd0, bus.WRAP},   {31'd0, m_wrap});
    if (bus.WRAP === 1'b1) wrap_cnt++;
    @(negedge CLK);
  endtask

  logic [W-1:0] rd;
  bit           rdu;

  initial begin
    bus.LOAD_n = 1'b1; bus.CTEN_n = 1'b1; bus.D_U = 1'b0; bus.D = '0;
    @(negedge CLK);

    // Clear beats load and count
    step(1, 0, 0, 1, 8'hA5);
    chk("rst_q", {24'd0, bus.Q}, 32'h00);
    chk("rst_max_min", {31'd0, bus.MAX_MIN}, 32'd1);
    chk("rst_rco_n",   {31'd0, bus.RCO_n},   32'd0);

    // Up through 0xFF -> 0x00
    step(0, 0, 1, 0, 8'hFE);
    step(0, 1, 0, 0, 8'h00);
    chk("up_ff_max_min", {31'd0, bus.MAX_MIN}, 32'd1);
    step(0, 1, 0, 0, 8'h00);
    chk("up_wrap_q", {24'd0, bus.Q}, 32'h00);
    chk("up_wrap",   {31'd0, bus.WRAP}, 32'd1);
    step(0, 1, 0, 0, 8'h00);
    chk("up_after_q", {24'd0, bus.Q}, 32'h01);

    // Borrow across the nibble boundary
    step(0, 0, 1, 1, 8'h10);
    step(0, 1, 0, 1, 8'h00);
    chk("borrow_q", {24'd0, bus.Q}, 32'h0F);
    step(0, 1, 0, 1, 8'h00);

    // Down through 0x00 -> 0xFF
    step(0, 0, 1, 1, 8'h01);
    step(0, 1, 0, 1, 8'h00);
    step(0, 1, 0, 1, 8'h00);
    chk("down_wrap_q", {24'd0, bus.Q}, 32'hFF);
    chk("down_wrap",   {31'd0, bus.WRAP}, 32'd1);

    // Load beats count, then clear beats load
    step(0, 0, 1, 0, 8'h33);
    step(0, 0, 0, 0, 8'hFF);
    chk("ld_pri_q", {24'd0, bus.Q}, 32'hFF);
    chk("ld_pri_wrap", {31'd0, bus.WRAP}, 32'd0);
    step(1, 0, 1, 0, 8'h77);

    // Hold at 0xFF, toggle direction, then count down
    step(0, 0, 1, 0, 8'hFF);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 8'h00);
    step(0, 1, 1, 1, 8'h00);
    step(0, 1, 0, 1, 8'h00);
    chk("toggle_q", {24'd0, bus.Q}, 32'hFE);

    // Full revolution: Q returns to start, one wrap
    step(0, 0, 1, 0, 8'h37);
    wrap_cnt = 0;
    for (int i = 0; i < MOD; i++) step(0, 1, 0, 0, 8'h00);
    chk("rev_q", {24'd0, bus.Q}, 32'h37);
    chk("rev_wraps", wrap_cnt, 32'd1);

    // Randomized traffic, biased toward terminal values
    rdu = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) rdu = ~rdu;
      case ($urandom_range(0, 4))
        0: rd = 8'h00;
        1: rd = 8'hFF;
        2: rd = 8'h01;
        3: rd = 8'hFE;
        default: rd = W'($urandom);
      endcase
      step($urandom_range(0, 29) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) == 0,
           rdu, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
